// File: rtl/adder_channel_loader.sv
// Serial-to-parallel, double-buffered loader feeding an N-input FP32 adder tree.
// One word per cycle fills a lane bank; a closed frame is handed to the output bank with a one-cycle valid pulse.
module adder_channel_loader #(
    parameter int N_CH   = 128,
    parameter int DATA_W = 32,
    localparam int CW    = $clog2(N_CH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        Data_In,
    input  logic                     Valid_In,
    input  logic                     Last_In,
    input  logic                     Clear_In,
    output logic [N_CH*DATA_W-1:0]   Data_Out,
    output logic                     Valid_Out,
    output logic [CW-1:0]            Count_Out,
    output logic [15:0]              Frame_Cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]              state_r;
    logic [CW-1:0]           count_r;
    logic [N_CH*DATA_W-1:0]  fill_bank_r;
    logic [N_CH*DATA_W-1:0]  out_bank_r;
    logic                    valid_r;
    logic [15:0]             frame_cnt_r;

    logic [N_CH*DATA_W-1:0]  merged_s;
    logic                    accept_s;
    logic                    close_s;
    logic                    abort_s;
    logic [0:0]              state_nxt_s;
    logic [CW-1:0]           count_nxt_s;
    logic [N_CH*DATA_W-1:0]  fill_nxt_s;

    // Lanes below the write pointer keep their data, the pointer lane takes the
    // incoming word and lanes above are forced to +0.0 so partial frames sum correctly.
    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_lane
            assign merged_s[DATA_W*k +: DATA_W] =
                (count_r > CW'(k))  ? fill_bank_r[DATA_W*k +: DATA_W] :
                (count_r == CW'(k)) ? Data_In :
                                      {DATA_W{1'b0}};
        end
    endgenerate

    // Accept / close / abort decode and next fill state.
    always_comb begin
        accept_s    = Valid_In & ~Clear_In;
        close_s     = accept_s & ((count_r == CW'(N_CH - 1)) | Last_In);
        abort_s     = Clear_In & (state_r == ST_FILL);
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        fill_nxt_s  = fill_bank_r;
        if (close_s || abort_s) begin
            state_nxt_s = ST_IDLE;
            count_nxt_s = {CW{1'b0}};
            fill_nxt_s  = {(N_CH*DATA_W){1'b0}};
        end else if (accept_s) begin
            state_nxt_s = ST_FILL;
            count_nxt_s = count_r + CW'(1);
            fill_nxt_s  = merged_s;
        end else begin
            state_nxt_s = state_r;
            count_nxt_s = count_r;
            fill_nxt_s  = fill_bank_r;
        end
    end

    // Fill-side state: write pointer, FSM state and fill bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            count_r     <= {CW{1'b0}};
            fill_bank_r <= {(N_CH*DATA_W){1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            count_r     <= count_nxt_s;
            fill_bank_r <= fill_nxt_s;
        end
    end

    // Output side: frame hand-off, valid pulse and completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bank_r  <= {(N_CH*DATA_W){1'b0}};
            valid_r     <= 1'b0;
            frame_cnt_r <= 16'h0000;
        end else begin
            valid_r <= close_s;
            if (close_s) begin
                out_bank_r  <= merged_s;
                frame_cnt_r <= frame_cnt_r + 16'h0001;
            end else begin
                out_bank_r  <= out_bank_r;
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign Data_Out  = out_bank_r;
    assign Valid_Out = valid_r;
    assign Count_Out = count_r;
    assign Frame_Cnt = frame_cnt_r;

endmodule

// File: tb/tb_adder_channel_loader.sv
// Scoreboard bench for adder_channel_loader: a lane model predicts each closed frame,
// which is queued when the closing word is driven and compared when Valid_Out pulses.
module tb_adder_channel_loader;

    localparam int N_CH   = 128;
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(N_CH) + 1;

    logic                    clk;
    logic                    rst_n;
    logic [DATA_W-1:0]       Data_In;
    logic                    Valid_In;
    logic                    Last_In;
    logic                    Clear_In;
    logic [N_CH*DATA_W-1:0]  Data_Out;
    logic                    Valid_Out;
    logic [CW-1:0]           Count_Out;
    logic [15:0]             Frame_Cnt;

    adder_channel_loader #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Data_In   (Data_In),
        .Valid_In  (Valid_In),
        .Last_In   (Last_In),
        .Clear_In  (Clear_In),
        .Data_Out  (Data_Out),
        .Valid_Out (Valid_Out),
        .Count_Out (Count_Out),
        .Frame_Cnt (Frame_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0]       mdl_lane [N_CH];
    int                      mdl_cnt;
    int                      mdl_frames;
    logic                    exp_valid;
    logic [N_CH*DATA_W-1:0]  last_frame;
    logic [N_CH*DATA_W-1:0]  frame_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fp_of(input int v);
        int e;
        e = 0;
        for (int b = 0; b < 31; b++) if (((v >> b) & 1) != 0) e = b;
        return {1'b0, 8'(127 + e), 23'((v << (23 - e)) & 32'h007F_FFFF)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) mdl_lane[i] = 32'h0000_0000;
        mdl_cnt    = 0;
        mdl_frames = 0;
        exp_valid  = 1'b0;
        last_frame = '0;
        frame_q.delete();
    endtask

    task automatic model_update(input logic v, input logic [31:0] d, input logic l, input logic c);
        logic [N_CH*DATA_W-1:0] f;
        exp_valid = 1'b0;
        if (c) begin
            for (int i = 0; i < N_CH; i++) mdl_lane[i] = 32'h0000_0000;
            mdl_cnt = 0;
        end else if (v) begin
            mdl_lane[mdl_cnt] = d;
            mdl_cnt++;
            if (mdl_cnt == N_CH || l) begin
                for (int i = 0; i < N_CH; i++) f[DATA_W*i +: DATA_W] = mdl_lane[i];
                frame_q.push_back(f);
                for (int i = 0; i < N_CH; i++) mdl_lane[i] = 32'h0000_0000;
                mdl_cnt    = 0;
                mdl_frames = (mdl_frames + 1) & 16'hFFFF;
                exp_valid  = 1'b1;
            end
        end
    endtask

    task automatic observe();
        logic [N_CH*DATA_W-1:0] f;
        int bad;
        check("count", 64'(Count_Out), 64'(mdl_cnt));
        check("valid", 64'(Valid_Out), 64'(exp_valid));
        check("frame_cnt", 64'(Frame_Cnt), 64'(mdl_frames));
        if (exp_valid) begin
            if (frame_q.size() == 0) begin
                check("queue_empty", 64'(0), 64'(1));
            end else begin
                f = frame_q.pop_front();
                bad = 0;
                for (int i = N_CH - 1; i >= 0; i--)
                    if (Data_Out[DATA_W*i +: DATA_W] !== f[DATA_W*i +: DATA_W]) bad = i;
                check($sformatf("frame_lane%0d", bad), 64'(Data_Out[DATA_W*bad +: DATA_W]),
                      64'(f[DATA_W*bad +: DATA_W]));
                last_frame = f;
            end
        end else begin
            check("hold", 64'(Data_Out == last_frame), 64'(1));
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic c);
        Valid_In = v;
        Data_In  = d;
        Last_In  = l;
        Clear_In = c;
        @(negedge clk);
        observe();
        model_update(v, d, l, c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0000_0000, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        Data_In  = '0;
        Valid_In = 1'b0;
        Last_In  = 1'b0;
        Clear_In = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 64'(|Data_Out), 64'(0));
        check("rst_valid", 64'(Valid_Out), 64'(0));
        check("rst_count", 64'(Count_Out), 64'(0));
        check("rst_fcnt", 64'(Frame_Cnt), 64'(0));
        rst_n = 1'b1;

        // Full frame 1.0 .. 128.0
        for (int i = 1; i <= N_CH; i++) step(1'b1, fp_of(i), 1'b0, 1'b0);
        idle(1);
        check("full_lane0", 64'(Data_Out[31:0]), 64'(32'h3F80_0000));
        check("full_lane127", 64'(Data_Out[DATA_W*127 +: DATA_W]), 64'(32'h4300_0000));
        check("full_fcnt", 64'(Frame_Cnt), 64'(1));

        // Clear while idle is a no-op, Last_In without Valid_In ignored
        step(1'b0, 32'h0000_0000, 1'b0, 1'b1);
        step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);

        // Early close after 5 words of 2.0
        for (int i = 0; i < 5; i++) step(1'b1, 32'h4000_0000, (i == 4), 1'b0);
        idle(1);
        check("early_lane4", 64'(Data_Out[DATA_W*4 +: DATA_W]), 64'(32'h4000_0000));
        check("early_lane5", 64'(Data_Out[DATA_W*5 +: DATA_W]), 64'(0));

        // Single-word frame carrying NaN bits
        step(1'b1, 32'h7FC0_1234, 1'b1, 1'b0);
        idle(2);

        // Back-to-back: 256 continuous words
        for (int i = 1; i <= 2 * N_CH; i++) step(1'b1, fp_of(i), 1'b0, 1'b0);
        idle(2);

        // Gapped input, Last_In on the final lane
        for (int i = 1; i <= N_CH; i++) begin
            step(1'b1, 32'h0100_0000 + 32'(i), (i == N_CH), 1'b0);
            step(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        end
        idle(2);

        // Clear mid-frame with a coincident valid word, then 128 words of 3.0
        for (int i = 1; i <= 40; i++) step(1'b1, fp_of(i + 200), 1'b0, 1'b0);
        step(1'b1, 32'h7F80_0000, 1'b0, 1'b1);
        for (int i = 0; i < N_CH; i++) step(1'b1, 32'h4040_0000, 1'b0, 1'b0);
        idle(1);
        check("clear_lane0", 64'(Data_Out[31:0]), 64'(32'h4040_0000));

        // Asynchronous reset at word 60, between edges
        for (int i = 1; i <= 60; i++) step(1'b1, fp_of(i), 1'b0, 1'b0);
        Valid_In = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", 64'(|Data_Out), 64'(0));
        check("arst_valid", 64'(Valid_Out), 64'(0));
        check("arst_count", 64'(Count_Out), 64'(0));
        check("arst_fcnt", 64'(Frame_Cnt), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        for (int i = 1; i <= N_CH; i++) step(1'b1, fp_of(i + 100), 1'b0, 1'b0);
        idle(1);
        check("arst_fcnt_after", 64'(Frame_Cnt), 64'(1));
        check("queue_drained", 64'(frame_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_channel_loader.md
Name: adder_channel_loader

Overview:
- Serial-to-parallel front end for the N-input FP32 adder tree (Adder_128input and its smaller siblings).
- Takes one FP32 word per cycle from a single stream and fills an N-lane frame.
- Presents the completed frame as a flat N×32 bus with a one-cycle Valid_Out pulse that drives the tree's Valid_In.
- Double-buffered, so streaming never stalls while the tree consumes the previous frame.

Parameters:
- N_CH, 128, number of lanes per frame; legal values 2, 4, 8, 16, 32, 64, 128.
- DATA_W, 32, lane width in bits; FP32, IEEE-754 single.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Data_In  input  DATA_W  incoming FP32 word.
- Valid_In  input  1  Data_In is valid this cycle; always accepted, no backpressure.
- Last_In  input  1  qualified by Valid_In; the current word closes the frame early.
- Clear_In  input  1  synchronous abort of the partially filled frame.
- Data_Out  output  N_CH*DATA_W  completed frame; lane k (0-based) on bits [DATA_W*k +: DATA_W], i.e. tree input Data(k+1).
- Valid_Out  output  1  one-cycle pulse; Data_Out holds a new frame.
- Count_Out  output  log2(N_CH)+1  number of words captured in the current fill frame.
- Frame_Cnt  output  16  completed-frame counter; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst_n low, asynchronous): fill bank, Data_Out, Valid_Out, Count_Out and Frame_Cnt all clear to 0. The fill bank is all lanes +0.0 (32'h0000_0000).
- Storage: one fill bank (N_CH×DATA_W) and one output bank driving Data_Out.
- Fill state machine, two states:
  - IDLE: Count_Out = 0.
  - FILL: 0 < Count_Out < N_CH.
- Accept (Valid_In=1, Clear_In=0): write Data_In into lane Count_Out; Count_Out increments; IDLE -> FILL on the first word.
- Frame close condition: accepted word with Count_Out == N_CH-1, or accepted word with Last_In=1.
- On close, in the same edge:
  - Output bank <= fill bank, with the closing word merged into its lane.
  - Lanes above the closing lane are forced to +0.0, so a partial frame sums correctly.
  - Fill bank clears to +0.0; Count_Out <= 0; state -> IDLE; Frame_Cnt increments.
  - Valid_Out = 1 in the following cycle only; latency is 1 cycle from the closing word to the Valid_Out pulse.
- Back-to-back frames: a word accepted in the cycle after a close goes to lane 0 of the new frame. Data_Out stays stable until the next close, so the adder tree may sample it any cycle while Valid_Out is high.
- Last_In with Valid_In=0 is ignored.
- Last_In on the first word: a 1-lane frame; lane 0 = Data_In, all other lanes +0.0.
- Last_In on lane N_CH-1: a single close, not a double close.
- Clear_In=1: fill bank -> +0.0, Count_Out -> 0, state -> IDLE; any Valid_In in the same cycle is dropped. The output bank, Valid_Out and Frame_Cnt are unaffected. Clear with Count_Out = 0 is a no-op.
- Reset asserted mid-frame: partial data is lost. No Valid_Out is produced for that frame, and none appears on reset release.
- Data is moved bit-exact; no FP interpretation (NaN, Inf and denormals pass untouched).

Test Plan:
- Full frame: N_CH=128, reset, then 128 consecutive Valid_In words 1.0, 2.0, …, 128.0.
  - Valid_Out pulses once, the cycle after word 128.
  - Lane 0 = 32'h3F80_0000; lane 127 = 32'h4300_0000 (128.0).
  - Frame_Cnt = 1; the downstream tree sum = 8256.0 (32'h4601_0000).
- Early close: 5 words of 2.0 (32'h4000_0000), Last_In on the 5th.
  - Lanes 0–4 = 32'h4000_0000; lanes 5–127 = 0.
  - Valid_Out pulses the next cycle; Count_Out returns to 0.
- Back-to-back: 256 words with Valid_In held continuously high.
  - Exactly two Valid_Out pulses, 128 cycles apart.
  - The second frame's lane 0 equals word 129.
  - Data_Out is unchanged between the pulses.
- Gapped input: 128 words with Valid_In toggling 1,0,1,0.
  - Single Valid_Out pulse after the 128th valid word; no lane skipped or duplicated.
- Clear: 40 words, then Clear_In=1 together with Valid_In=1, then 128 words of 3.0.
  - The word coinciding with Clear_In is dropped; no Valid_Out appears before the 128th new word.
  - The frame contains only 3.0 (32'h4040_0000); Frame_Cnt increments by 1.
- Async reset: drop rst_n mid-frame at word 60, asynchronously between edges.
  - All outputs read 0 immediately, before the next clock edge.
  - After release, the next 128 words produce one correct frame with Frame_Cnt = 1.
